// File: rtl/mac_acc_lanes.sv
// mac_acc_lanes: LANES-wide signed multiply-accumulate over first/last delimited runs, 3-stage pipeline.
// Define MAC_ACC_SAT_EN for saturating accumulation with per-lane sticky overflow flags.
module mac_acc_lanes #(
  parameter int WIDTH     = 8,
  parameter int LANES     = 4,
  parameter int ACC_WIDTH = 2*WIDTH+8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ce,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_first,
  input  logic                       in_last,
  input  logic [LANES*WIDTH-1:0]     a,
  input  logic [LANES*WIDTH-1:0]     b,
  input  logic [ACC_WIDTH-1:0]       bias,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*ACC_WIDTH-1:0] p,
  output logic [LANES-1:0]           out_ovf
);

  localparam int PW = 2*WIDTH;

  logic                        w_adv;

  logic                        r_s1_valid;
  logic                        r_s1_first;
  logic                        r_s1_last;
  logic [LANES*WIDTH-1:0]      r_s1_a;
  logic [LANES*WIDTH-1:0]      r_s1_b;
  logic [ACC_WIDTH-1:0]        r_s1_bias;

  logic signed [PW-1:0]        w_prod [LANES];
  logic                        r_s2_valid;
  logic                        r_s2_first;
  logic                        r_s2_last;
  logic [ACC_WIDTH-1:0]        r_s2_bias;
  logic signed [PW-1:0]        r_s2_prod [LANES];

  logic signed [ACC_WIDTH-1:0] w_base [LANES];
  logic signed [ACC_WIDTH-1:0] w_sum [LANES];
  logic [LANES-1:0]            w_clamp;
  logic [LANES-1:0]            w_ovf_next;
  logic signed [ACC_WIDTH-1:0] r_acc [LANES];
  logic [LANES-1:0]            r_run_ovf;
  logic                        r_s3_emit;
  logic [LANES*ACC_WIDTH-1:0]  r_s3_sum;
  logic [LANES-1:0]            r_s3_ovf;

  logic                        r_out_valid;
  logic [LANES*ACC_WIDTH-1:0]  r_p;
  logic [LANES-1:0]            r_out_ovf;

`ifdef MAC_ACC_SAT_EN
  // Returns {clamped, result}; overflow is detected from the extra sum bit disagreeing with the sign bit.
  function automatic logic [ACC_WIDTH:0] sat_add(input logic signed [ACC_WIDTH-1:0] x,
                                                 input logic signed [ACC_WIDTH-1:0] y);
    logic signed [ACC_WIDTH:0] full;
    logic [ACC_WIDTH:0]        res;
    full = (ACC_WIDTH+1)'(x) + (ACC_WIDTH+1)'(y);
    if (full[ACC_WIDTH] != full[ACC_WIDTH-1]) begin
      if (full[ACC_WIDTH]) begin
        res = {1'b1, 1'b1, {(ACC_WIDTH-1){1'b0}}};
      end else begin
        res = {1'b1, 1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
    end else begin
      res = {1'b0, full[ACC_WIDTH-1:0]};
    end
    return res;
  endfunction
`endif

  // The whole pipeline, output register included, moves only when the output slot can take a result.
  assign w_adv     = ce && !(r_out_valid && !out_ready);
  assign in_ready  = w_adv;
  assign out_valid = r_out_valid;
  assign p         = r_p;
  assign out_ovf   = r_out_ovf;

  // S1: capture accepted beat and its tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_bias  <= '0;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      r_s1_first <= in_first;
      r_s1_last  <= in_last;
      r_s1_a     <= a;
      r_s1_b     <= b;
      r_s1_bias  <= bias;
    end
  end

  // Full-precision signed lane products.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_prod[i] = PW'($signed(r_s1_a[i*WIDTH +: WIDTH])) * PW'($signed(r_s1_b[i*WIDTH +: WIDTH]));
    end
  end

  // S2: register products, carry tags forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_first <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_bias  <= '0;
      for (int i = 0; i < LANES; i++) begin
        r_s2_prod[i] <= '0;
      end
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid;
      r_s2_first <= r_s1_first;
      r_s2_last  <= r_s1_last;
      r_s2_bias  <= r_s1_bias;
      for (int i = 0; i < LANES; i++) begin
        r_s2_prod[i] <= w_prod[i];
      end
    end
  end

  // Accumulate step: a first beat reseeds from bias and discards any open partial sum.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_base[i] = r_s2_first ? $signed(r_s2_bias) : r_acc[i];
`ifdef MAC_ACC_SAT_EN
      {w_clamp[i], w_sum[i]} = sat_add(w_base[i], ACC_WIDTH'(r_s2_prod[i]));
`else
      w_clamp[i] = 1'b0;
      w_sum[i]   = w_base[i] + ACC_WIDTH'(r_s2_prod[i]);
`endif
      w_ovf_next[i] = (r_s2_first ? 1'b0 : r_run_ovf[i]) | w_clamp[i];
    end
  end

  // S3: running accumulator; a last beat snapshots the sum for output and clears the lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s3_emit <= 1'b0;
      r_s3_sum  <= '0;
      r_s3_ovf  <= '0;
      r_run_ovf <= '0;
      for (int i = 0; i < LANES; i++) begin
        r_acc[i] <= '0;
      end
    end else if (w_adv) begin
      r_s3_emit <= r_s2_valid && r_s2_last;
      if (r_s2_valid) begin
        r_s3_ovf <= w_ovf_next;
        for (int i = 0; i < LANES; i++) begin
          r_s3_sum[i*ACC_WIDTH +: ACC_WIDTH] <= w_sum[i];
        end
        if (r_s2_last) begin
          r_run_ovf <= '0;
          for (int i = 0; i < LANES; i++) begin
            r_acc[i] <= '0;
          end
        end else begin
          r_run_ovf <= w_ovf_next;
          for (int i = 0; i < LANES; i++) begin
            r_acc[i] <= w_sum[i];
          end
        end
      end
    end
  end

  // Output register: advancing implies any pending result was handed off this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_p         <= '0;
      r_out_ovf   <= '0;
    end else if (w_adv) begin
      r_out_valid <= r_s3_emit;
      if (r_s3_emit) begin
        r_p       <= r_s3_sum;
        r_out_ovf <= r_s3_ovf;
      end
    end
  end

endmodule
